pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised elastic pipeline register, the successor to the fixed ID/EX latch. It carries PC, instruction and a generic payload between two CPU stages with a valid/ready handshake, a two-entry skid buffer, flush-to-bubble and a saturating stall counter. The first instances are ID/EX and EX/MEM, where it replaces hard-wired stall/flush muxing.

## Interface
Parameters:
- `PC_W`, 32, PC width
- `PAYLOAD_W`, 97, width of bundled stage data (e.g. rs/rt/imm + flag)
- `RESET_PC`, 32'h0000_3000, PC value held after reset
- `CNT_W`, 16, stall-counter width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge clears state
- `in_valid` in 1: upstream has a beat
- `in_ready` out 1: block accepts a beat this cycle
- `in_pc` in PC_W: upstream PC
- `in_instr` in 32: upstream instruction
- `in_payload` in PAYLOAD_W: upstream data
- `flush` in 1: discard all held and incoming beats
- `out_valid` out 1: beat presented downstream
- `out_ready` in 1: downstream consumes beat
- `out_pc` out PC_W: held PC
- `out_instr` out 32: held instruction; 0 (NOP) when `out_valid==0`
- `out_payload` out PAYLOAD_W: held data; 0 when `out_valid==0`
- `stall_cnt` out CNT_W: cycles with `out_valid & !out_ready`, saturating

## Operation
- Storage: main register (drives outputs) and skid register; each holds pc/instr/payload.
- States: EMPTY (neither valid), ONE (main valid), TWO (main and skid valid).
- Transfer in = `in_valid & in_ready`; transfer out = `out_valid & out_ready`.
- `in_ready = reset & (state != TWO)`: combinational from the state register only, never from `out_ready`.
- `out_valid = (state != EMPTY)`.
- EMPTY: transfer in → ONE, main ← in.
- ONE:
  - in and out → ONE, main ← in.
  - in only → TWO, skid ← in.
  - out only → EMPTY, main data ← 0, PC retained.
  - neither → hold.
- TWO: out → ONE, main ← skid. Otherwise hold. No input is accepted.
- Flush: any state → EMPTY at the edge. The incoming beat that cycle is dropped even if `in_ready==1`. Main/skid instr and payload ← 0. `out_pc` retains its last value.
- Priority: reset > flush > handshake.
- Stall counter: increments by 1 when `out_valid & !out_ready`. It holds at all-ones and does not wrap. Flush does not clear it; only reset does.

## Timing
- Reset values:
  - state EMPTY
  - `out_valid`=0, `out_instr`=0, `out_payload`=0
  - `out_pc`=RESET_PC
  - `stall_cnt`=0
  - `in_ready`=0 during the reset cycle and 1 the cycle after
- Latency: a beat accepted at edge N is on the outputs after edge N, i.e. 1 cycle.
- Throughput is 1 beat/cycle with `out_ready` held high. `in_ready` drops the cycle after the first back-pressured accept.
- Beats are never duplicated, reordered or lost, except by flush or reset.
- Reset mid-operation: both entries are discarded, with the same values as power-up reset.
- Simultaneous flush and `out_ready`: the downstream beat counts as consumed. The state goes to EMPTY.

## Structure
- Shared package `pipe_pkg`:
  - state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2)
  - `NOP_INSTR`=32'h0
  - default `RESET_PC`
- Sub-module `sat_counter`: width `CNT_W`, with enable and synchronous active-low clear. It implements `stall_cnt`.
- Entry registers are plain always-blocks in the top module. No memory inference.

## Test plan
- Reset: hold `reset=0` two cycles with `in_valid=1`. Required: `in_ready=0`, `out_valid=0`, `out_pc=32'h3000`, `stall_cnt=0`. After release, `in_ready=1`.
- Streaming: `out_ready=1`, feed PCs 0x3000, 0x3004, 0x3008 on consecutive cycles. Required: the same PCs on `out_pc` one cycle later, `out_valid` continuously 1, no drops.
- Back-pressure: `out_ready=0`, feed A, B, C.
  - Required: A on outputs, B in skid, `in_ready=0` so C is held upstream, `stall_cnt` increments each cycle.
  - Then raise `out_ready`. Required order on outputs: A, B, C.
- Flush in TWO: with A and B held, assert `flush` plus `in_valid` with D. Required next cycle: `out_valid=0`, `out_instr=0`, `out_payload=0`, `in_ready=1`, D absent thereafter.
- Saturation: `CNT_W=4`, hold `out_valid=1` and `out_ready=0` for 20 cycles. Required: `stall_cnt=15`, stable.
- Reset while in TWO: `reset=0` for one cycle. Required: state EMPTY, outputs at reset values, then normal streaming resumes.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: entry-state encoding,
// the bubble instruction and the default post-reset PC.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear;
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register between two CPU stages: valid/ready handshake,
// two-entry skid buffer, flush-to-bubble and a saturating stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int             PC_W      = 32,
  parameter int             PAYLOAD_W = 97,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
  parameter int             CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [31:0]          out_instr,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt
);

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [31:0]            main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [PAYLOAD_W-1:0]   main_pl_q, main_pl_d, skid_pl_q, skid_pl_d;
  logic                   xfer_in, xfer_out;

  // in_ready looks only at the state register so it never combinationally
  // depends on downstream out_ready.
  assign in_ready  = reset & (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    main_pl_d    = main_pl_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pl_d    = skid_pl_q;
    if (flush) begin
      // PC is kept so out_pc still shows the last beat during the bubble.
      state_d      = ST_EMPTY;
      main_instr_d = NOP_INSTR;
      main_pl_d    = '0;
      skid_instr_d = NOP_INSTR;
      skid_pl_d    = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (xfer_in) begin
          state_d      = ST_ONE;
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
          main_pl_d    = in_payload;
        end
        ST_ONE: begin
          if (xfer_in && xfer_out) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
            main_pl_d    = in_payload;
          end else if (xfer_in) begin
            state_d      = ST_TWO;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
            skid_pl_d    = in_payload;
          end else if (xfer_out) begin
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
            main_pl_d    = '0;
          end
        end
        ST_TWO: if (xfer_out) begin
          state_d      = ST_ONE;
          main_pc_d    = skid_pc_q;
          main_instr_d = skid_instr_q;
          main_pl_d    = skid_pl_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= RESET_PC;
      main_instr_q <= NOP_INSTR;
      main_pl_q    <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pl_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      main_pl_q    <= main_pl_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pl_q    <= skid_pl_d;
    end
  end

  assign out_pc      = main_pc_q;
  assign out_instr   = main_instr_q;
  assign out_payload = main_pl_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr_n(reset),
    .en   (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand sequences and random
// traffic checked against a queue-based model of the beat stream.
module tb_pipe_skid_reg;

  localparam int PC_W      = 32;
  localparam int PAYLOAD_W = 97;
  localparam int CNT_W     = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [PC_W-1:0]      in_pc, out_pc;
  logic [31:0]          in_instr, out_instr;
  logic [PAYLOAD_W-1:0] in_payload, out_payload;
  logic [CNT_W-1:0]     stall_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .PC_W     (PC_W),
    .PAYLOAD_W(PAYLOAD_W),
    .RESET_PC (RST_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_payload (in_payload),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_payload(out_payload),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic [PC_W-1:0]      pc;
    logic [31:0]          instr;
    logic [PAYLOAD_W-1:0] pl;
  } beat_t;

  typedef struct {
    logic        rst, iv, orr, fl;
    logic [31:0] pc;
    logic        ir, ov;
    logic [31:0] epc;
    int unsigned cnt;
  } vec_t;

  beat_t       mq[$];
  logic [31:0] m_pc;
  int unsigned m_cnt;
  bit          model_ok = 0;
  int          n_cmp = 0, n_bad = 0;
  vec_t        tv[22];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] payload_of(input logic [31:0] pc);
    return {pc, ~pc, pc + 32'd1, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    bit          ov;
    logic [31:0] epc, ein;
    logic [PAYLOAD_W-1:0] epl;
    if (!model_ok) return;
    ov  = (mq.size() != 0);
    epc = ov ? mq[0].pc : m_pc;
    ein = ov ? mq[0].instr : 32'h0;
    epl = ov ? mq[0].pl : '0;
    chk("m_in_ready", 128'(in_ready), 128'(reset && mq.size() < 2));
    chk("m_out_valid", 128'(out_valid), 128'(ov));
    chk("m_out_pc", 128'(out_pc), 128'(epc));
    chk("m_out_instr", 128'(out_instr), 128'(ein));
    chk("m_out_payload", 128'(out_payload), 128'(epl));
    chk("m_stall_cnt", 128'(stall_cnt), 128'(m_cnt));
  endtask

  task automatic model_edge();
    bit acc;
    if (!reset) begin
      mq.delete();
      m_pc     = RST_PC;
      m_cnt    = 0;
      model_ok = 1;
    end else begin
      acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (mq.size() > 0) m_pc = mq[0].pc;
      if (flush) mq.delete();
      else begin
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (acc) mq.push_back('{in_pc, in_instr, in_payload});
      end
      if (mq.size() > 0) m_pc = mq[0].pc;
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [31:0] pc,
                       input logic orr, input logic fl);
    reset      = rst;
    in_valid   = iv;
    in_pc      = pc;
    in_instr   = instr_of(pc);
    in_payload = payload_of(pc);
    out_ready  = orr;
    flush      = fl;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    //        rst iv  or  fl  pc            ir  ov  out_pc        cnt
    tv[0]  = '{0, 1, 1, 0, 32'h0000_3000, 0, 0, 32'h0000_3000, 0};
    tv[1]  = '{1, 1, 1, 0, 32'h0000_3000, 1, 0, 32'h0000_3000, 0};
    tv[2]  = '{1, 1, 1, 0, 32'h0000_3004, 1, 1, 32'h0000_3000, 0};
    tv[3]  = '{1, 1, 1, 0, 32'h0000_3008, 1, 1, 32'h0000_3004, 0};
    tv[4]  = '{1, 0, 1, 0, 32'h0000_0000, 1, 1, 32'h0000_3008, 0};
    tv[5]  = '{1, 1, 0, 0, 32'h0000_0100, 1, 0, 32'h0000_3008, 0};
    tv[6]  = '{1, 1, 0, 0, 32'h0000_0104, 1, 1, 32'h0000_0100, 0};
    tv[7]  = '{1, 1, 0, 0, 32'h0000_0108, 0, 1, 32'h0000_0100, 1};
    tv[8]  = '{1, 1, 1, 0, 32'h0000_0108, 0, 1, 32'h0000_0100, 2};
    tv[9]  = '{1, 1, 1, 0, 32'h0000_0108, 1, 1, 32'h0000_0104, 2};
    tv[10] = '{1, 0, 0, 0, 32'h0000_0000, 1, 1, 32'h0000_0108, 2};
    tv[11] = '{1, 1, 0, 0, 32'h0000_010C, 1, 1, 32'h0000_0108, 3};
    tv[12] = '{1, 1, 0, 1, 32'h0000_0110, 0, 1, 32'h0000_0108, 4};
    tv[13] = '{1, 0, 1, 0, 32'h0000_0000, 1, 0, 32'h0000_0108, 5};
    tv[14] = '{1, 1, 0, 0, 32'h0000_0200, 1, 0, 32'h0000_0108, 5};
    tv[15] = '{1, 1, 0, 0, 32'h0000_0204, 1, 1, 32'h0000_0200, 5};
    tv[16] = '{0, 1, 0, 0, 32'h0000_0208, 0, 1, 32'h0000_0200, 6};
    tv[17] = '{1, 1, 1, 0, 32'h0000_0300, 1, 0, 32'h0000_3000, 0};
    tv[18] = '{1, 0, 1, 0, 32'h0000_0000, 1, 1, 32'h0000_0300, 0};
    tv[19] = '{1, 1, 0, 0, 32'h0000_0400, 1, 0, 32'h0000_0300, 0};
    tv[20] = '{1, 1, 1, 1, 32'h0000_0404, 1, 1, 32'h0000_0400, 0};
    tv[21] = '{1, 0, 1, 0, 32'h0000_0000, 1, 0, 32'h0000_0400, 0};

    drive(0, 1, RST_PC, 1, 0);
    @(posedge clk);
    model_edge();
    #1;

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].iv, tv[i].pc, tv[i].orr, tv[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(tv[i].ir));
      chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(tv[i].ov));
      chk($sformatf("v%0d_out_pc", i), 128'(out_pc), 128'(tv[i].epc));
      chk($sformatf("v%0d_out_instr", i), 128'(out_instr),
          128'(tv[i].ov ? instr_of(tv[i].epc) : 32'h0));
      chk($sformatf("v%0d_out_payload", i), 128'(out_payload),
          128'(tv[i].ov ? payload_of(tv[i].epc) : '0));
      chk($sformatf("v%0d_stall_cnt", i), 128'(stall_cnt), 128'(tv[i].cnt));
      model_check();
      @(posedge clk);
      model_edge();
      #1;
    end

    // Saturation: one beat held with out_ready low for 20 cycles.
    drive(1, 1, 32'h0000_0500, 0, 0);
    cycle();
    drive(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 20; i++) cycle();
    @(negedge clk);
    chk("sat_cnt", 128'(stall_cnt), 128'(15));
    chk("sat_out_pc", 128'(out_pc), 128'(32'h0000_0500));
    @(posedge clk);
    model_edge();
    #1;
    @(negedge clk);
    chk("sat_cnt_stable", 128'(stall_cnt), 128'(15));
    @(posedge clk);
    model_edge();
    #1;
    // Flush must not clear the counter.
    drive(1, 0, 32'h0, 0, 1);
    cycle();
    drive(1, 0, 32'h0, 1, 0);
    @(negedge clk);
    chk("flush_keeps_cnt", 128'(stall_cnt), 128'(15));
    chk("flush_bubble", 128'(out_valid), 128'(0));
    @(posedge clk);
    model_edge();
    #1;

    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 59) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      in_pc      = $urandom();
      in_instr   = $urandom();
      in_payload = {$urandom(), $urandom(), $urandom(), 1'($urandom())};
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
